// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    // Sequencer states: normal issue, waiting on the LSU, latched LSU timeout.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_e;

    // Per-stage control bundle driven to the pipeline registers.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic memwb_flush;
    } stage_ctrl_t;

    // Instruction the stage registers load when flushed (addi x0, x0, 0).
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Free-running pipeline: everything advances, nothing is cleared.
    function automatic stage_ctrl_t ctrl_flow();
        stage_ctrl_t c;
        c.pc_en       = 1'b1;
        c.ifid_en     = 1'b1;
        c.ifid_flush  = 1'b0;
        c.idex_en     = 1'b1;
        c.idex_flush  = 1'b0;
        c.exmem_en    = 1'b1;
        c.memwb_flush = 1'b0;
        return c;
    endfunction

    // Whole front end frozen, a bubble is pushed into WB.
    function automatic stage_ctrl_t ctrl_freeze();
        stage_ctrl_t c;
        c.pc_en       = 1'b0;
        c.ifid_en     = 1'b0;
        c.ifid_flush  = 1'b0;
        c.idex_en     = 1'b0;
        c.idex_flush  = 1'b0;
        c.exmem_en    = 1'b0;
        c.memwb_flush = 1'b1;
        return c;
    endfunction

    // True when a source register is read and matches the producing rd.
    function automatic logic src_hit(input logic used, input logic [4:0] rs, input logic [4:0] rd);
        return used && (rs == rd);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_r;

    // Count register: clear wins, then increment unless already saturated.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r <= '0;
        end else if (clr_i) begin
            cnt_r <= '0;
        end else if (inc_i && (cnt_r != {W{1'b1}})) begin
            cnt_r <= cnt_r + W'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt_o = cnt_r;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch flush,
// LSU wait with timeout watchdog, and saturating debug event counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic             ex_rd_wren_i,
    input  logic             ex_is_load_i,
    input  logic             id_br_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             pc_en_o,
    output logic             ifid_en_o,
    output logic             ifid_flush_o,
    output logic             idex_en_o,
    output logic             idex_flush_o,
    output logic             exmem_en_o,
    output logic             memwb_flush_o,
    output logic             mem_err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    state_e      state_r, state_s;
    logic [7:0]  wait_r, wait_s;
    logic        mem_err_r, mem_err_s;
    logic        lu_s, mw_s, ack_s;
    stage_ctrl_t run_ctrl_s, ctrl_s;

    // Hazard sources; an ack without a pending request means nothing.
    assign lu_s  = ex_is_load_i && ex_rd_wren_i && (ex_rd_addr_i != 5'd0) &&
                   (src_hit(id_rs1_used_i, id_rs1_addr_i, ex_rd_addr_i) ||
                    src_hit(id_rs2_used_i, id_rs2_addr_i, ex_rd_addr_i));
    assign mw_s  = mem_req_i && !mem_ack_i;
    assign ack_s = mem_req_i && mem_ack_i;

    // Normal-issue response: load-use bubble beats branch flush.
    always_comb begin
        run_ctrl_s = ctrl_flow();
        if (lu_s) begin
            run_ctrl_s.pc_en      = 1'b0;
            run_ctrl_s.ifid_en    = 1'b0;
            run_ctrl_s.idex_flush = 1'b1;
        end else if (id_br_taken_i) begin
            run_ctrl_s.ifid_flush = 1'b1;
        end else begin
            run_ctrl_s = ctrl_flow();
        end
    end

    // Next state, wait counter, fault flag and stage controls.
    always_comb begin
        state_s   = state_r;
        wait_s    = wait_r;
        mem_err_s = mem_err_r;
        ctrl_s    = run_ctrl_s;
        case (state_r)
            RUN: begin
                if (mw_s) begin
                    ctrl_s  = ctrl_freeze();
                    state_s = MEM_WAIT;
                    wait_s  = 8'd1;
                end else begin
                    ctrl_s  = run_ctrl_s;
                end
            end
            MEM_WAIT: begin
                if (ack_s) begin
                    ctrl_s  = run_ctrl_s;
                    state_s = RUN;
                    wait_s  = 8'd0;
                end else if (wait_r >= 8'(TIMEOUT_CYC)) begin
                    ctrl_s    = ctrl_freeze();
                    state_s   = FAULT;
                    wait_s    = 8'd0;
                    mem_err_s = 1'b1;
                end else begin
                    ctrl_s  = ctrl_freeze();
                    wait_s  = wait_r + 8'd1;
                end
            end
            FAULT: begin
                ctrl_s    = ctrl_freeze();
                mem_err_s = 1'b1;
            end
            default: begin
                // Corrupted state encoding is treated as an LSU fault.
                ctrl_s    = ctrl_freeze();
                state_s   = FAULT;
                wait_s    = 8'd0;
                mem_err_s = 1'b1;
            end
        endcase
    end

    // State, wait counter and sticky fault registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= RUN;
            wait_r    <= 8'd0;
            mem_err_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            wait_r    <= wait_s;
            mem_err_r <= mem_err_s;
        end
    end

    assign pc_en_o       = ctrl_s.pc_en;
    assign ifid_en_o     = ctrl_s.ifid_en;
    assign ifid_flush_o  = ctrl_s.ifid_flush;
    assign idex_en_o     = ctrl_s.idex_en;
    assign idex_flush_o  = ctrl_s.idex_flush;
    assign exmem_en_o    = ctrl_s.exmem_en;
    assign memwb_flush_o = ctrl_s.memwb_flush;
    assign mem_err_o     = mem_err_r;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (1'b0),
        .inc_i  (!ctrl_s.pc_en),
        .cnt_o  (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (1'b0),
        .inc_i  (ctrl_s.ifid_flush),
        .cnt_o  (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed bench for pipe_hazard_ctrl against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int TO  = 4;
    localparam int CW  = 4;
    localparam int SAT = 15;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [4:0]    id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i;
    logic          id_rs1_used_i, id_rs2_used_i, ex_rd_wren_i, ex_is_load_i;
    logic          id_br_taken_i, mem_req_i, mem_ack_i;
    logic          pc_en_o, ifid_en_o, ifid_flush_o, idex_en_o, idex_flush_o;
    logic          exmem_en_o, memwb_flush_o, mem_err_o;
    logic [CW-1:0] stall_cnt_o, flush_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: cycles spent waiting (0 = not waiting), fault latch, counters.
    int m_wait;
    bit m_fault;
    int m_stall;
    int m_flush;

    pipe_hazard_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .id_rs1_addr_i (id_rs1_addr_i),
        .id_rs2_addr_i (id_rs2_addr_i),
        .id_rs1_used_i (id_rs1_used_i),
        .id_rs2_used_i (id_rs2_used_i),
        .ex_rd_addr_i  (ex_rd_addr_i),
        .ex_rd_wren_i  (ex_rd_wren_i),
        .ex_is_load_i  (ex_is_load_i),
        .id_br_taken_i (id_br_taken_i),
        .mem_req_i     (mem_req_i),
        .mem_ack_i     (mem_ack_i),
        .pc_en_o       (pc_en_o),
        .ifid_en_o     (ifid_en_o),
        .ifid_flush_o  (ifid_flush_o),
        .idex_en_o     (idex_en_o),
        .idex_flush_o  (idex_flush_o),
        .exmem_en_o    (exmem_en_o),
        .memwb_flush_o (memwb_flush_o),
        .mem_err_o     (mem_err_o),
        .stall_cnt_o   (stall_cnt_o),
        .flush_cnt_o   (flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        id_rs1_addr_i = 5'd0; id_rs2_addr_i = 5'd0; ex_rd_addr_i = 5'd0;
        id_rs1_used_i = 1'b0; id_rs2_used_i = 1'b0;
        ex_rd_wren_i  = 1'b0; ex_is_load_i  = 1'b0;
        id_br_taken_i = 1'b0; mem_req_i = 1'b0; mem_ack_i = 1'b0;
    endtask

    // Expected controls {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush}.
    function automatic logic [6:0] model_ctrl();
        bit lu, mw, ack;
        lu  = ex_is_load_i && ex_rd_wren_i && (ex_rd_addr_i != 5'd0) &&
              ((id_rs1_used_i && id_rs1_addr_i == ex_rd_addr_i) ||
               (id_rs2_used_i && id_rs2_addr_i == ex_rd_addr_i));
        mw  = mem_req_i && !mem_ack_i;
        ack = mem_req_i && mem_ack_i;
        if (m_fault || mw || (m_wait > 0 && !ack)) return 7'b0000001;
        if (lu)                                    return 7'b0001110;
        if (id_br_taken_i)                         return 7'b1111010;
        return 7'b1101010;
    endfunction

    // One clock: compare at negedge+1 with current inputs, then advance the model.
    task automatic run_cycle();
        logic [6:0] ec;
        bit ack;
        #1;
        ec = model_ctrl();
        chk("ctrl", 32'({pc_en_o, ifid_en_o, ifid_flush_o, idex_en_o, idex_flush_o,
                         exmem_en_o, memwb_flush_o}), 32'(ec));
        chk("mem_err", 32'(mem_err_o), 32'(m_fault));
        chk("stall_cnt", 32'(stall_cnt_o), 32'(m_stall));
        chk("flush_cnt", 32'(flush_cnt_o), 32'(m_flush));
        @(posedge clk_i);
        ack = mem_req_i && mem_ack_i;
        if (!ec[6] && m_stall < SAT) m_stall++;
        if (ec[4] && m_flush < SAT) m_flush++;
        if (!m_fault) begin
            if (m_wait > 0) begin
                if (ack)               m_wait = 0;
                else if (m_wait >= TO) begin m_fault = 1'b1; m_wait = 0; end
                else                   m_wait++;
            end else if (mem_req_i && !mem_ack_i) begin
                m_wait = 1;
            end
        end
        @(negedge clk_i);
    endtask

    task automatic model_reset();
        m_wait = 0; m_fault = 1'b0; m_stall = 0; m_flush = 0;
    endtask

    // Reset held for two cycles, released on a falling edge.
    task automatic do_reset();
        idle_inputs();
        rst_ni = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1, input logic use1);
        ex_is_load_i = 1'b1; ex_rd_wren_i = 1'b1; ex_rd_addr_i = rd;
        id_rs1_addr_i = rs1; id_rs1_used_i = use1;
    endtask

    initial begin
        idle_inputs();
        rst_ni = 1'b0;
        model_reset();
        do_reset();

        // Reset state with idle inputs.
        run_cycle();

        // Load-use: one bubble, then flow.
        set_load(5'd5, 5'd5, 1'b1);
        run_cycle();
        ex_is_load_i = 1'b0;
        run_cycle();
        chk("lu_stall_once", 32'(stall_cnt_o), 32'd1);

        // Load to x0 is never a hazard.
        set_load(5'd0, 5'd0, 1'b1);
        run_cycle();
        chk("x0_no_stall", 32'(pc_en_o), 32'd1);
        idle_inputs();

        // Branch alone, then branch with load-use (flush deferred one cycle).
        do_reset();
        id_br_taken_i = 1'b1;
        run_cycle();
        id_br_taken_i = 1'b0;
        run_cycle();
        chk("br_flush_cnt", 32'(flush_cnt_o), 32'd1);
        id_br_taken_i = 1'b1;
        set_load(5'd7, 5'd7, 1'b1);
        run_cycle();
        ex_is_load_i = 1'b0;
        run_cycle();
        idle_inputs();
        run_cycle();
        chk("br_lu_flush_cnt", 32'(flush_cnt_o), 32'd2);

        // LSU ack after three wait cycles.
        do_reset();
        mem_req_i = 1'b1;
        repeat (3) run_cycle();
        mem_ack_i = 1'b1;
        run_cycle();
        idle_inputs();
        run_cycle();
        chk("ack3_stall_cnt", 32'(stall_cnt_o), 32'd3);

        // Timeout: fault after TO wait cycles, sticky regardless of inputs.
        do_reset();
        mem_req_i = 1'b1;
        repeat (5) run_cycle();
        chk("timeout_err", 32'(mem_err_o), 32'd1);
        mem_ack_i = 1'b1;
        repeat (3) run_cycle();
        chk("fault_sticky", 32'(mem_err_o), 32'd1);
        chk("fault_frozen", 32'(pc_en_o), 32'd0);
        // Keep stalling in FAULT until the stall counter saturates (20 stall cycles total).
        repeat (12) run_cycle();
        chk("stall_sat", 32'(stall_cnt_o), 32'(SAT));
        #2 rst_ni = 1'b0;
        idle_inputs();
        #1;
        chk("rst_clears_err", 32'(mem_err_o), 32'd0);
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Asynchronous reset while in MEM_WAIT; ack-less drop of req stays waiting.
        mem_req_i = 1'b1;
        run_cycle();
        mem_req_i = 1'b0;
        mem_ack_i = 1'b1;
        run_cycle();
        #2 rst_ni = 1'b0;
        mem_ack_i = 1'b0;
        #1;
        chk("async_rst_run", 32'(pc_en_o), 32'd1);
        chk("async_rst_cnt", 32'(stall_cnt_o), 32'd0);
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Randomized segments, each from reset.
        for (int seg = 0; seg < 30; seg++) begin
            do_reset();
            for (int cyc = 0; cyc < 25; cyc++) begin
                id_rs1_addr_i = 5'($urandom_range(0, 3));
                id_rs2_addr_i = 5'($urandom_range(0, 3));
                ex_rd_addr_i  = 5'($urandom_range(0, 3));
                id_rs1_used_i = 1'($urandom_range(0, 1));
                id_rs2_used_i = 1'($urandom_range(0, 1));
                ex_rd_wren_i  = 1'($urandom_range(0, 3) != 0);
                ex_is_load_i  = 1'($urandom_range(0, 1));
                id_br_taken_i = 1'($urandom_range(0, 2) == 0);
                mem_req_i     = 1'($urandom_range(0, 2) == 0) || (m_wait > 0 && $urandom_range(0, 3) != 0);
                mem_ack_i     = 1'($urandom_range(0, 2) == 0);
                run_cycle();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
